// File: rtl/hub_fifo_scheduler_pkg.sv
// Shared definitions for the hub FIFO scheduler: message geometry, the broadcast
// destination and a helper that extracts the destination FPGA-ID field.
package hub_fifo_scheduler_pkg;

    localparam int HUB_FIFO_WIDTH = 32;
    localparam int FPGAID_WIDTH   = 4;

    localparam logic [FPGAID_WIDTH-1:0] BROADCAST_ID = '1;

    typedef logic [HUB_FIFO_WIDTH-1:0] msg_t;
    typedef logic [FPGAID_WIDTH-1:0]   fpga_id_t;

    // The destination occupies the most significant bits of every message.
    function automatic fpga_id_t dest_id(input msg_t msg);
        return msg[HUB_FIFO_WIDTH-1 -: FPGAID_WIDTH];
    endfunction

endpackage

// File: rtl/hub_fifo_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or
// after ptr in cyclic order. The caller owns and advances the pointer.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    logic [PTR_W-1:0] idx;

    // Walk the cyclic order backwards so the candidate closest to ptr is written last and wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first; a missed path would infer a latch.
        grant = '0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = PTR_W'((int'(ptr) + k) % N);
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hub_fifo_scheduler.sv
// Hub message scheduler: round-robin merge of downstream channels into one
// upstream register, FPGA-ID routing of upstream messages, and status aggregation.
module hub_fifo_scheduler
    import hub_fifo_scheduler_pkg::*;
#(
    parameter int DOWNSTREAM_FIFO_COUNT = 4
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [DOWNSTREAM_FIFO_COUNT*HUB_FIFO_WIDTH-1:0] down_in_data,
    input  logic [DOWNSTREAM_FIFO_COUNT-1:0]            down_in_valid,
    output logic [DOWNSTREAM_FIFO_COUNT-1:0]            down_in_ready,
    output logic [HUB_FIFO_WIDTH-1:0]                   up_out_data,
    output logic                                        up_out_valid,
    input  logic                                        up_out_ready,
    input  logic [HUB_FIFO_WIDTH-1:0]                   up_in_data,
    input  logic                                        up_in_valid,
    output logic                                        up_in_ready,
    output logic [DOWNSTREAM_FIFO_COUNT*HUB_FIFO_WIDTH-1:0] down_out_data,
    output logic [DOWNSTREAM_FIFO_COUNT-1:0]            down_out_valid,
    input  logic [DOWNSTREAM_FIFO_COUNT-1:0]            down_out_ready,
    input  logic [DOWNSTREAM_FIFO_COUNT-1:0]            downstream_has_message_flying,
    input  logic [DOWNSTREAM_FIFO_COUNT-1:0]            downstream_has_odd_clusters,
    output logic                                        upstream_has_message_flying,
    output logic                                        upstream_has_odd_clusters,
    output logic                                        route_error
);

    localparam int N     = DOWNSTREAM_FIFO_COUNT;
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    // Upstream merge state
    msg_t             up_reg;
    logic             up_valid;
    logic [PTR_W-1:0] rr_ptr;
    logic             up_load_ok;
    logic [N-1:0]     req;
    logic [N-1:0]     grant;
    logic [PTR_W-1:0] grant_idx;
    msg_t             grant_data;

    // Downstream route state
    msg_t             dn_reg;
    logic [N-1:0]     pend;
    logic             up_accept;
    fpga_id_t         dest;

    // A full register that is draining this cycle can take a new grant with no bubble.
    assign up_load_ok = !up_valid || up_out_ready;
    assign req        = down_in_valid & {N{up_load_ok}};

    rr_arbiter #(
        .N     (N),
        .PTR_W (PTR_W)
    ) u_arb (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) grant_idx = PTR_W'(i);
        end
        grant_data = down_in_data[int'(grant_idx)*HUB_FIFO_WIDTH +: HUB_FIFO_WIDTH];
    end

    assign down_in_ready = grant;
    assign up_out_data   = up_reg;
    assign up_out_valid  = up_valid;

    // NOTE: sequential state is written with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            up_reg   <= '0;
            up_valid <= 1'b0;
            rr_ptr   <= '0;
        end else if (|grant) begin
            up_reg   <= grant_data;
            up_valid <= 1'b1;
            rr_ptr   <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
        end else if (up_out_ready) begin
            up_valid <= 1'b0;
        end
    end

    assign up_in_ready    = (pend == '0);
    assign up_accept      = up_in_valid && up_in_ready;
    assign dest           = dest_id(up_in_data);
    assign down_out_valid = pend;
    assign down_out_data  = {N{dn_reg}};

    // Unicast to a channel that does not exist is dropped and flagged until reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dn_reg      <= '0;
            pend        <= '0;
            route_error <= 1'b0;
        end else if (up_accept) begin
            dn_reg <= up_in_data;
            if (dest == BROADCAST_ID) begin
                pend <= '1;
            end else if (int'(dest) < N) begin
                pend <= N'(1) << dest;
            end else begin
                pend        <= '0;
                route_error <= 1'b1;
            end
        end else begin
            pend <= pend & ~down_out_ready;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            upstream_has_message_flying <= 1'b0;
            upstream_has_odd_clusters   <= 1'b0;
        end else begin
            upstream_has_message_flying <= (|downstream_has_message_flying) || (|down_in_valid)
                                           || up_valid || up_in_valid || (pend != '0);
            upstream_has_odd_clusters   <= |downstream_has_odd_clusters;
        end
    end

endmodule

// File: tb/tb_hub_fifo_scheduler.sv
// Self-checking bench for hub_fifo_scheduler: directed scenarios pinned by literal
// expectations, then randomized traffic compared every cycle against a behavioural model.
module tb_hub_fifo_scheduler;

    localparam int N = 4;
    localparam int W = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [N*W-1:0]   down_in_data;
    logic [N-1:0]     down_in_valid;
    logic [N-1:0]     down_in_ready;
    logic [W-1:0]     up_out_data;
    logic             up_out_valid;
    logic             up_out_ready;
    logic [W-1:0]     up_in_data;
    logic             up_in_valid;
    logic             up_in_ready;
    logic [N*W-1:0]   down_out_data;
    logic [N-1:0]     down_out_valid;
    logic [N-1:0]     down_out_ready;
    logic [N-1:0]     downstream_has_message_flying;
    logic [N-1:0]     downstream_has_odd_clusters;
    logic             upstream_has_message_flying;
    logic             upstream_has_odd_clusters;
    logic             route_error;

    hub_fifo_scheduler #(.DOWNSTREAM_FIFO_COUNT(N)) dut (
        .clk                           (clk),
        .reset                         (reset),
        .down_in_data                  (down_in_data),
        .down_in_valid                 (down_in_valid),
        .down_in_ready                 (down_in_ready),
        .up_out_data                   (up_out_data),
        .up_out_valid                  (up_out_valid),
        .up_out_ready                  (up_out_ready),
        .up_in_data                    (up_in_data),
        .up_in_valid                   (up_in_valid),
        .up_in_ready                   (up_in_ready),
        .down_out_data                 (down_out_data),
        .down_out_valid                (down_out_valid),
        .down_out_ready                (down_out_ready),
        .downstream_has_message_flying (downstream_has_message_flying),
        .downstream_has_odd_clusters   (downstream_has_odd_clusters),
        .upstream_has_message_flying   (upstream_has_message_flying),
        .upstream_has_odd_clusters     (upstream_has_odd_clusters),
        .route_error                   (route_error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: what the visible registers must hold after the last clock edge.
    bit           m_up_v;
    logic [W-1:0] m_up_d;
    int           m_ptr;
    logic [N-1:0] m_pend;
    logic [W-1:0] m_dn;
    bit           m_err;
    bit           m_fly;
    bit           m_odd;
    int           last_grant;
    bit           last_up_acc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_up_v = 0; m_up_d = '0; m_ptr = 0; m_pend = '0; m_dn = '0;
        m_err = 0; m_fly = 0; m_odd = 0; last_grant = -1; last_up_acc = 0;
    endtask

    task automatic clear_inputs();
        down_in_data = '0; down_in_valid = '0; up_out_ready = 1'b0;
        up_in_data = '0; up_in_valid = 1'b0; down_out_ready = '0;
        downstream_has_message_flying = '0; downstream_has_odd_clusters = '0;
    endtask

    // Called at a falling edge with this cycle's inputs applied; returns at the next falling edge.
    task automatic tick();
        int           g;
        bit           acc;
        logic [N-1:0] exp_rdy;
        logic [3:0]   d;
        bit           n_up_v;
        logic [W-1:0] n_up_d;
        int           n_ptr;
        logic [N-1:0] n_pend;
        logic [W-1:0] n_dn;
        bit           n_err, n_fly, n_odd;
        #1;
        check("up_out_valid", up_out_valid, m_up_v);
        if (m_up_v) check("up_out_data", up_out_data, m_up_d);
        check("down_out_valid", down_out_valid, m_pend);
        for (int i = 0; i < N; i++)
            if (m_pend[i]) check($sformatf("down_out_data[%0d]", i), down_out_data[i*W +: W], m_dn);
        check("route_error", route_error, m_err);
        check("status_flying", upstream_has_message_flying, m_fly);
        check("status_odd", upstream_has_odd_clusters, m_odd);

        g = -1;
        if (!m_up_v || up_out_ready)
            for (int k = 0; k < N; k++)
                if (g < 0 && down_in_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
        check("down_in_ready", down_in_ready, exp_rdy);
        check("up_in_ready", up_in_ready, m_pend == '0);

        if (g >= 0) begin
            n_up_v = 1; n_up_d = down_in_data[g*W +: W]; n_ptr = (g + 1) % N;
        end else begin
            n_up_v = m_up_v && !up_out_ready; n_up_d = m_up_d; n_ptr = m_ptr;
        end
        acc = up_in_valid && (m_pend == '0);
        n_dn = m_dn; n_err = m_err;
        if (acc) begin
            d = up_in_data[W-1 -: 4];
            n_dn = up_in_data;
            if (d == 4'hF) n_pend = '1;
            else if (int'(d) < N) n_pend = N'(1) << d;
            else begin n_pend = '0; n_err = 1; end
        end else begin
            n_pend = m_pend & ~down_out_ready;
        end
        n_fly = (downstream_has_message_flying != 0) || (down_in_valid != 0) || m_up_v
                || up_in_valid || (m_pend != 0);
        n_odd = (downstream_has_odd_clusters != 0);

        @(posedge clk);
        m_up_v = n_up_v; m_up_d = n_up_d; m_ptr = n_ptr; m_pend = n_pend; m_dn = n_dn;
        m_err = n_err; m_fly = n_fly; m_odd = n_odd;
        last_grant = g; last_up_acc = acc;
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] rand_msg();
        int r;
        logic [3:0] d;
        r = $urandom_range(0, 9);
        if (r < 3) d = 4'hF;
        else if (r < 8) d = 4'(r % N);
        else d = 4'($urandom_range(4, 14));
        return {d, 28'($urandom)};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] log_up [5];

        reset = 1'b1;
        clear_inputs();
        model_reset();
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_up_in_ready", up_in_ready, 1);
        check("rst_down_in_ready", down_in_ready, 0);
        check("rst_down_out_valid", down_out_valid, 0);
        check("rst_up_out_valid", up_out_valid, 0);
        check("rst_route_error", route_error, 0);
        check("rst_status_flying", upstream_has_message_flying, 0);
        check("rst_status_odd", upstream_has_odd_clusters, 0);
        reset = 1'b1;
        tick(); tick();
        check("idle_up_in_ready", up_in_ready, 1);
        check("idle_status_flying", upstream_has_message_flying, 0);
        check("idle_down_out_valid", down_out_valid, 0);

        // All four channels held valid: grants rotate 0,1,2,3,0.
        for (int i = 0; i < N; i++) down_in_data[i*W +: W] = 32'hA0 + i;
        down_in_valid = '1;
        up_out_ready  = 1'b1;
        for (int t = 0; t < 5; t++) begin
            tick();
            log_up[t] = up_out_data;
            check($sformatf("rr_valid_%0d", t), up_out_valid, 1);
        end
        check("rr_seq0", log_up[0], 32'hA0);
        check("rr_seq1", log_up[1], 32'hA1);
        check("rr_seq2", log_up[2], 32'hA2);
        check("rr_seq3", log_up[3], 32'hA3);
        check("rr_seq4", log_up[4], 32'hA0);
        down_in_valid = '0;
        tick(); tick();

        // Single persistent channel is granted every cycle.
        down_in_valid = 4'b0100;
        repeat (3) begin
            tick();
            check("single_grant_data", up_out_data, 32'hA2);
        end
        down_in_valid = '0;
        tick(); tick();

        // Unicast to channel 2 with back-pressure.
        up_in_data = 32'h2000_1234; up_in_valid = 1'b1; down_out_ready = '0;
        tick();
        up_in_valid = 1'b0;
        check("uni_valid", down_out_valid, 4'b0100);
        repeat (5) begin
            tick();
            check("uni_hold_data", down_out_data[2*W +: W], 32'h2000_1234);
            check("uni_hold_ready", up_in_ready, 0);
        end
        down_out_ready = 4'b0100;
        tick();
        down_out_ready = '0;
        check("uni_done_ready", up_in_ready, 1);
        check("uni_done_valid", down_out_valid, 0);

        // Broadcast; channels ready in cycles 1, 3, 3, 6.
        up_in_data = 32'hFFFF_0001; up_in_valid = 1'b1;
        tick();
        up_in_valid = 1'b0;
        check("bc_valid", down_out_valid, 4'hF);
        for (int c = 1; c <= 6; c++) begin
            down_out_ready = {c >= 6, c >= 3, c >= 3, c >= 1};
            tick();
            if (c == 1) check("bc_after1", down_out_valid, 4'b1110);
            if (c == 3) check("bc_after3", down_out_valid, 4'b1000);
            if (c == 5) check("bc_busy", up_in_ready, 0);
        end
        check("bc_done_ready", up_in_ready, 1);
        check("bc_done_valid", down_out_valid, 0);
        down_out_ready = '0;

        // Destination 9 does not exist: dropped, sticky error.
        up_in_data = 32'h9000_00AB; up_in_valid = 1'b1;
        tick();
        up_in_valid = 1'b0;
        check("bad_err", route_error, 1);
        check("bad_valid", down_out_valid, 0);
        check("bad_ready", up_in_ready, 1);
        repeat (3) tick();
        check("bad_sticky", route_error, 1);

        downstream_has_odd_clusters = 4'b0100;
        tick();
        check("odd_status", upstream_has_odd_clusters, 1);
        downstream_has_odd_clusters = '0;
        tick();

        // Asynchronous reset in the middle of a broadcast.
        up_in_data = 32'hF000_0055; up_in_valid = 1'b1;
        tick();
        up_in_valid = 1'b0;
        down_out_ready = 4'b0001;
        tick();
        down_out_ready = '0;
        #3 reset = 1'b0;
        #1;
        check("mid_rst_down_valid", down_out_valid, 0);
        check("mid_rst_up_valid", up_out_valid, 0);
        check("mid_rst_up_in_ready", up_in_ready, 1);
        check("mid_rst_route_error", route_error, 0);
        check("mid_rst_flying", upstream_has_message_flying, 0);
        clear_inputs();
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Randomized traffic obeying the valid/ready protocol.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!down_in_valid[i] || last_grant == i) begin
                    down_in_valid[i] = ($urandom_range(0, 99) < 60);
                    down_in_data[i*W +: W] = $urandom;
                end
            end
            if (!up_in_valid || last_up_acc) begin
                up_in_valid = ($urandom_range(0, 99) < 50);
                up_in_data  = rand_msg();
            end
            up_out_ready   = ($urandom_range(0, 99) < 70);
            down_out_ready = N'($urandom);
            downstream_has_message_flying = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
            downstream_has_odd_clusters   = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            if (cyc % 200 > 190) begin
                if (last_grant >= 0) down_in_valid[last_grant] = 1'b0;
                if (last_up_acc) up_in_valid = 1'b0;
            end
            tick();
        end

        clear_inputs();
        up_out_ready = 1'b1; down_out_ready = '1;
        repeat (6) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hub_fifo_scheduler.md
# hub_fifo_scheduler

Message scheduler inside a hub between the single upstream FIFO channel (toward the master stage controller) and DOWNSTREAM_FIFO_COUNT downstream FIFO channels (toward leaf FPGAs). Upstream-bound traffic from all downstream channels is merged by round-robin arbitration. Downstream-bound traffic is routed by its FPGA-ID field, either unicast to one channel or broadcast to all. The block also aggregates the per-channel has_message_flying / has_odd_clusters status into registered upstream status bits.

## Interface
- DOWNSTREAM_FIFO_COUNT, 4: number of downstream channels (1..15).
- HUB_FIFO_WIDTH, 32: message width; destination FPGA ID occupies bits [HUB_FIFO_WIDTH-1 -: FPGAID_WIDTH].
- FPGAID_WIDTH, 4: destination field width; all-ones means broadcast.

Ports:
- clk  in  1  single clock.
- reset  in  1  reset, asynchronous, active-low.
- down_in_data  in  DOWNSTREAM_FIFO_COUNT*HUB_FIFO_WIDTH  upstream-bound messages; channel i occupies slice i.
- down_in_valid  in  DOWNSTREAM_FIFO_COUNT  per-channel valid.
- down_in_ready  out  DOWNSTREAM_FIFO_COUNT  per-channel ready.
- up_out_data  out  HUB_FIFO_WIDTH  merged upstream message.
- up_out_valid  out  1  merged message valid.
- up_out_ready  in  1  upstream ready.
- up_in_data  in  HUB_FIFO_WIDTH  downstream-bound message.
- up_in_valid  in  1  downstream-bound message valid.
- up_in_ready  out  1  ready for a downstream-bound message.
- down_out_data  out  DOWNSTREAM_FIFO_COUNT*HUB_FIFO_WIDTH  routed messages; every slice carries the same held word.
- down_out_valid  out  DOWNSTREAM_FIFO_COUNT  per-channel valid.
- down_out_ready  in  DOWNSTREAM_FIFO_COUNT  per-channel ready.
- downstream_has_message_flying  in  DOWNSTREAM_FIFO_COUNT  per-channel status.
- downstream_has_odd_clusters  in  DOWNSTREAM_FIFO_COUNT  per-channel status.
- upstream_has_message_flying  out  1  registered aggregate status.
- upstream_has_odd_clusters  out  1  registered aggregate status.
- route_error  out  1  sticky flag: a unicast message addressed a non-existent channel.

## Operation
- Handshake on every port: a transfer occurs in a cycle where valid and ready are both high. Valid, once asserted, never depends on ready.
- **Upstream merge**
  - One output register, up_reg, with a valid bit.
  - up_reg may load when it is empty or up_out_ready is high.
  - When it may load, the grant goes to the first valid channel at or after rr_ptr (cyclic order). down_in_ready is high only for the granted channel.
  - After a grant, rr_ptr is set to grant+1, wrapping to 0 after DOWNSTREAM_FIFO_COUNT-1. rr_ptr is unchanged when there is no grant.
- **Downstream route**
  - One holding register, dn_reg, plus pending mask pend[DOWNSTREAM_FIFO_COUNT-1:0].
  - up_in_ready = (pend == 0).
  - On accept, decode the destination field:
    - all-ones: pend = all ones (broadcast).
    - value < DOWNSTREAM_FIFO_COUNT: pend = one-hot(value).
    - otherwise: pend = 0, the message is dropped, and route_error is set.
  - down_out_valid = pend. Bit i of pend clears when down_out_ready[i] is high.
  - A broadcast completes when the last pending bit clears; channels may accept in different cycles.
- **Status aggregation**, registered every cycle:
  - upstream_has_message_flying = |downstream_has_message_flying | |down_in_valid | up_reg valid | up_in_valid | (pend != 0).
  - upstream_has_odd_clusters = |downstream_has_odd_clusters.

## Timing
- Reset values: up_out_valid=0, down_out_valid=0, pend=0, rr_ptr=0, route_error=0, both status outputs 0, data registers 0. After reset, up_in_ready=1 and down_in_ready=0.
- Latency:
  - Upstream: 1 cycle from input handshake to up_out_valid.
  - Downstream: 1 cycle from up_in handshake to down_out_valid.
  - Status: 1 cycle.
- Throughput:
  - Upstream: 1 message/cycle. When up_reg is full and up_out_ready=1, a new grant loads in the same cycle, with no bubble.
  - Downstream: 1 message per 2 cycles, minimum. up_in_ready is low in the cycle the last pending bit clears.
- Simultaneous events:
  - All channels valid: grants rotate 0,1,2,3,0…
  - A single persistently valid channel is granted every cycle.
- Reset asserted mid-operation: everything clears immediately (asynchronously). In-flight messages are lost. route_error clears only on reset.
- up_out_data and down_out_data hold stable while their valid is high and the transfer has not completed.

## Structure
- Shared package: HUB_FIFO_WIDTH, FPGAID_WIDTH, the BROADCAST_ID constant (all ones), and a function returning the destination field.
- Sub-module `rr_arbiter` (request vector and pointer in, one-hot grant out, combinational). The scheduler instantiates it and owns rr_ptr.
- Expected size: ~200 lines of RTL.

## Test plan
- Reset, then idle → up_in_ready=1, all down_out_valid=0, both status outputs 0.
- Channels 0–3 held valid with payloads 0xA0..0xA3, up_out_ready=1 → up_out_data sequence is A0,A1,A2,A3,A0, one per cycle after a 1-cycle latency.
- Unicast dest=2 (0x2xxxxxxx) → only down_out_valid[2] rises the next cycle. With down_out_ready[2] held low for 5 cycles, data stays stable and up_in_ready=0 throughout.
- Broadcast 0xFFFF0001; channels become ready in cycles 1, 3, 3, 6 → each valid bit drops individually, and up_in_ready returns high one cycle after the last ready.
- dest=9 with DOWNSTREAM_FIFO_COUNT=4 → message dropped, route_error=1 and sticky, up_in_ready stays 1.
- Drive downstream_has_odd_clusters=4'b0100 → upstream_has_odd_clusters=1 one cycle later. Assert reset mid-broadcast → pend clears and outputs return to reset values.
